// File: rtl/rw_control_logic.sv
// CPU-side read/write control for the 8259 core: registered buffer enables,
// ICW1..ICW4 initialisation sequencing, OCW1..OCW3 decode and register read-back.
module rw_control_logic #(
    parameter logic [7:0] IMR_RESET  = 8'h00,
    parameter logic       RSEL_RESET = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CS_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic       A0,
    input  logic [7:0] InternalD_IN,
    input  logic [7:0] IRR,
    input  logic [7:0] ISR,
    output logic [7:0] InternalD_OUT,
    output logic       R,
    output logic       W,
    output logic [7:0] ICW1,
    output logic [7:0] ICW2,
    output logic [7:0] ICW3,
    output logic [7:0] ICW4,
    output logic [7:0] IMR,
    output logic [7:0] OCW2,
    output logic       OCW2_Valid,
    output logic       Init_Done
);

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    state_t     state_q, state_d;
    logic       r_q, r_d, w_q, w_d, wr_prev_q, wr_prev_d;
    logic [7:0] wdat_q, wdat_d;
    logic       wa0_q, wa0_d;
    logic [7:0] dout_q, dout_d;
    logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d;
    logic [7:0] icw3_q, icw3_d, icw4_q, icw4_d;
    logic [7:0] imr_q, imr_d, ocw2_q, ocw2_d;
    logic       ocw2_valid_q, ocw2_valid_d;
    logic       init_done_q, init_done_d;
    logic       rsel_q, rsel_d;
    logic       commit;

    always_comb begin
        state_d      = state_q;
        icw1_d       = icw1_q;
        icw2_d       = icw2_q;
        icw3_d       = icw3_q;
        icw4_d       = icw4_q;
        imr_d        = imr_q;
        ocw2_d       = ocw2_q;
        rsel_d       = rsel_q;
        wdat_d       = wdat_q;
        wa0_d        = wa0_q;
        ocw2_valid_d = 1'b0;
        // Simultaneous RD_n/WR_n low enables neither direction
        r_d          = ~(~CS_n & ~RD_n & WR_n);
        w_d          = ~(~CS_n & ~WR_n & RD_n);
        wr_prev_d    = w_q;
        dout_d       = A0 ? imr_q : (rsel_q ? ISR : IRR);
        if (!w_q) begin
            wdat_d = InternalD_IN;
            wa0_d  = A0;
        end
        commit = w_q & ~wr_prev_q;
        if (commit) begin
            if (!wa0_q && wdat_q[4]) begin
                icw1_d  = wdat_q;
                icw2_d  = 8'h00;
                icw3_d  = 8'h00;
                icw4_d  = 8'h00;
                imr_d   = IMR_RESET;
                rsel_d  = RSEL_RESET;
                state_d = WAIT_ICW2;
            end else begin
                case (state_q)
                    WAIT_ICW2: if (wa0_q) begin
                        icw2_d = wdat_q;
                        if (!icw1_q[1])     state_d = WAIT_ICW3;
                        else if (icw1_q[0]) state_d = WAIT_ICW4;
                        else                state_d = READY;
                    end
                    WAIT_ICW3: if (wa0_q) begin
                        icw3_d  = wdat_q;
                        state_d = icw1_q[0] ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: if (wa0_q) begin
                        icw4_d  = wdat_q;
                        state_d = READY;
                    end
                    READY: begin
                        if (wa0_q) begin
                            imr_d = wdat_q;
                        end else if (wdat_q[4:3] == 2'b00) begin
                            ocw2_d       = wdat_q;
                            ocw2_valid_d = 1'b1;
                        end else if (wdat_q[1]) begin
                            rsel_d = wdat_q[0];
                        end
                    end
                    default: ;
                endcase
            end
        end
        init_done_d = (state_d == READY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= UNINIT;
            r_q          <= 1'b1;
            w_q          <= 1'b1;
            wr_prev_q    <= 1'b1;
            wdat_q       <= 8'h00;
            wa0_q        <= 1'b0;
            dout_q       <= 8'h00;
            icw1_q       <= 8'h00;
            icw2_q       <= 8'h00;
            icw3_q       <= 8'h00;
            icw4_q       <= 8'h00;
            imr_q        <= IMR_RESET;
            ocw2_q       <= 8'h00;
            ocw2_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
            rsel_q       <= RSEL_RESET;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            w_q          <= w_d;
            wr_prev_q    <= wr_prev_d;
            wdat_q       <= wdat_d;
            wa0_q        <= wa0_d;
            dout_q       <= dout_d;
            icw1_q       <= icw1_d;
            icw2_q       <= icw2_d;
            icw3_q       <= icw3_d;
            icw4_q       <= icw4_d;
            imr_q        <= imr_d;
            ocw2_q       <= ocw2_d;
            ocw2_valid_q <= ocw2_valid_d;
            init_done_q  <= init_done_d;
            rsel_q       <= rsel_d;
        end
    end

    assign InternalD_OUT = dout_q;
    assign R             = r_q;
    assign W             = w_q;
    assign ICW1          = icw1_q;
    assign ICW2          = icw2_q;
    assign ICW3          = icw3_q;
    assign ICW4          = icw4_q;
    assign IMR           = imr_q;
    assign OCW2          = ocw2_q;
    assign OCW2_Valid    = ocw2_valid_q;
    assign Init_Done     = init_done_q;

endmodule
